// File: rtl/ex_div_ctrl.sv
// Multi-cycle divide/remainder unit for the EX stage.
// A restoring radix-2 divider works on operand magnitudes. Sign fix-up and
// the quotient/remainder select happen in a single FIX cycle afterwards.
// Divide-by-zero and signed overflow skip the iteration and complete in one cycle.
module ex_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quot_q, rem_q, dvsr_q;
  logic            neg_quot_q, neg_rem_q, is_rem_q, word_q;

  logic            accept;
  logic            is_signed, a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0] a_eff, b_eff, a_mag, b_mag, min_val, special_res;
  logic [XLEN:0]   rem_shift, diff;
  logic [XLEN-1:0] q_fix, r_fix, fix_res;

  // Only divide ops are routed here, so funct3[2] is always set and carries no information.
  logic unused_funct3;
  assign unused_funct3 = funct3_i[2];

  // W results keep the low half and sign-extend its top bit across the full width.
  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Decode the incoming operands: effective width, magnitudes and the two short-cut cases.
  always_comb begin
    is_signed = ~funct3_i[0];
    a_eff     = dividend_i;
    b_eff     = divisor_i;
    min_val   = {1'b1, {(XLEN-1){1'b0}}};
    if (word_i) begin
      a_eff   = is_signed ? {{HALF{dividend_i[HALF-1]}}, dividend_i[HALF-1:0]}
                          : {{HALF{1'b0}}, dividend_i[HALF-1:0]};
      b_eff   = is_signed ? {{HALF{divisor_i[HALF-1]}}, divisor_i[HALF-1:0]}
                          : {{HALF{1'b0}}, divisor_i[HALF-1:0]};
      min_val = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end
    a_neg       = is_signed & a_eff[XLEN-1];
    b_neg       = is_signed & b_eff[XLEN-1];
    a_mag       = a_neg ? -a_eff : a_eff;
    b_mag       = b_neg ? -b_eff : b_eff;
    div_zero    = (b_eff == '0);
    overflow    = is_signed & (a_eff == min_val) & (b_eff == '1);
    special     = div_zero | overflow;
    special_res = fit(div_zero ? (funct3_i[1] ? a_eff : '1)
                               : (funct3_i[1] ? '0 : a_eff), word_i);
  end

  // One restoring step plus the final sign fix-up and result select.
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvsr_q};
    q_fix     = neg_quot_q ? -quot_q : quot_q;
    r_fix     = neg_rem_q ? -rem_q : rem_q;
    fix_res   = fit(is_rem_q ? r_fix : q_fix, word_q);
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall_o = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        stall_o = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = ~flush_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, iteration datapath and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      word_q     <= 1'b0;
      result_o   <= '0;
    end else begin
      if (accept) begin
        cnt_q      <= word_i ? CW'(HALF) : CW'(XLEN);
        quot_q     <= word_i ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
        rem_q      <= '0;
        dvsr_q     <= b_mag;
        neg_quot_q <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        is_rem_q   <= funct3_i[1];
        word_q     <= word_i;
        if (special) result_o <= special_res;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CW'(1);
        if (!diff[XLEN]) begin
          rem_q  <= diff[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q  <= rem_shift[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b0};
        end
      end
      if (state_q == FIX && state_d == DONE) result_o <= fix_res;
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Randomized scoreboard bench for ex_div_ctrl with directed corner cases.
module tb_ex_div_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst, start_i, flush_i, word_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] dividend_i, divisor_i;
  logic            stall_o, busy_o, done_o;
  logic [XLEN-1:0] result_o;

  typedef struct {
    logic [63:0] res;
    int          due;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          stall_run = 0;
  logic [63:0] last_res  = '0;

  ex_div_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .word_i(word_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .stall_o(stall_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%016h expected=0x%016h", name, actual, expected);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic at the effective width.
  task automatic modelDiv(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
    bit          sgn, isrem;
    int          sa, sb;
    int unsigned ua, ub;
    longint      la, lb;
    logic [31:0] r32;
    sgn   = !f3[0];
    isrem = f3[1];
    if (w) begin
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      if (ub == 0) begin
        r32 = isrem ? a[31:0] : 32'hFFFF_FFFF; lat = 1;
      end else if (sgn && sa == 32'sh8000_0000 && sb == -1) begin
        r32 = isrem ? 32'h0 : a[31:0]; lat = 1;
      end else begin
        lat = 34;
        if (sgn) r32 = isrem ? sa % sb : sa / sb;
        else     r32 = isrem ? ua % ub : ua / ub;
      end
      res = {{32{r32[31]}}, r32};
    end else begin
      la = a; lb = b;
      if (b == 0) begin
        res = isrem ? a : '1; lat = 1;
      end else if (sgn && la == 64'sh8000_0000_0000_0000 && lb == -1) begin
        res = isrem ? '0 : a; lat = 1;
      end else begin
        lat = 66;
        if (sgn) res = isrem ? la % lb : la / lb;
        else     res = isrem ? a % b : a / b;
      end
    end
  endtask

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return 64'($urandom_range(1, 20));
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'h0000_0000_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one operation in the current (idle) cycle, then wait until the unit is idle again.
  task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                               input logic directed, input logic [63:0] dir_res, input int dir_lat);
    exp_t        e;
    logic [63:0] mres;
    int          mlat;
    int          waited;
    modelDiv(f3, w, a, b, mres, mlat);
    e.res = directed ? dir_res : mres;
    e.lat = directed ? dir_lat : mlat;
    e.due = cyc + e.lat;
    sb_q.push_back(e);
    funct3_i = f3; word_i = w; dividend_i = a; divisor_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
    dividend_i = {$urandom, $urandom};
    divisor_i  = {$urandom, $urandom};
    funct3_i   = {1'b1, 2'($urandom_range(0, 3))};
    word_i     = 1'($urandom_range(0, 1));
    waited     = 0;
    while (busy_o === 1'b1 && waited < 200) begin
      start_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start_i = 1'b0;
      waited++;
    end
    if (busy_o !== 1'b0) checkOutput("busy_timeout", busy_o, 64'h0);
  endtask

  // Monitor: pop an expectation whenever done_o fires and track the stall window.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", done_o, 64'h0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("result", result_o, e.res);
        checkOutput("done_cycle", 64'(cyc), 64'(e.due));
        checkOutput("stall_cycles", 64'(stall_run), 64'(e.lat));
        checkOutput("stall_in_done", stall_o, 64'h0);
        last_res = e.res;
      end
      stall_run = 0;
    end else if (stall_o === 1'b1) begin
      stall_run++;
    end else begin
      stall_run = 0;
    end
  end

  initial begin
    int waited;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = 3'b100;
    word_i = 1'b0; dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy_o, 64'h0);
    checkOutput("reset_done", done_o, 64'h0);
    checkOutput("reset_stall", stall_o, 64'h0);
    checkOutput("reset_result", result_o, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(3'b101, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 66);
    applyStimulus(3'b110, 1'b0, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    applyStimulus(3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    applyStimulus(3'b100, 1'b0, 64'd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    applyStimulus(3'b111, 1'b0, 64'd5, 64'd0, 1'b1, 64'd5, 1);
    applyStimulus(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 64'h8000_0000_0000_0000, 1);
    applyStimulus(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 64'h0, 1);
    applyStimulus(3'b111, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h1234_5678_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1);
    applyStimulus(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    applyStimulus(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 34);

    $display("[TB] flush mid-calculation");
    funct3_i = 3'b101; word_i = 1'b0; dividend_i = 64'd1000; divisor_i = 64'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checkOutput("flush_busy", busy_o, 64'h0);
    checkOutput("flush_stall", stall_o, 64'h0);
    checkOutput("flush_result_held", result_o, last_res);
    @(posedge clk); #1;
    applyStimulus(3'b101, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 66);

    $display("[TB] flush beats start in idle");
    funct3_i = 3'b101; dividend_i = 64'd9; divisor_i = 64'd2; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    checkOutput("flush_prio_busy", busy_o, 64'h0);

    $display("[TB] reset mid-calculation");
    funct3_i = 3'b100; word_i = 1'b0; dividend_i = 64'd12345; divisor_i = 64'd11; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_res = '0;
    checkOutput("midreset_busy", busy_o, 64'h0);
    checkOutput("midreset_done", done_o, 64'h0);
    checkOutput("midreset_stall", stall_o, 64'h0);
    checkOutput("midreset_result", result_o, 64'h0);
    @(posedge clk); #1;

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a, b;
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      w  = 1'($urandom_range(0, 1));
      a  = randOperand();
      b  = randOperand();
      applyStimulus(f3, w, a, b, 1'b0, 64'h0, 0);
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("scoreboard_drain", 64'(sb_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request a divide/remainder operation; sampled only in IDLE.
REQ-005 SHALL have port flush_i  input  1  abort the in-flight operation (branch/jump flush).
REQ-006 SHALL have port funct3_i  input  3  operation: 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 SHALL have port word_i  input  1  W variant (divw, divuw, remw, remuw): operate on low XLEN/2 bits.
REQ-008 SHALL have port dividend_i  input  XLEN  rs1 operand, already forwarded by EX.
REQ-009 SHALL have port divisor_i  input  XLEN  rs2 operand, already forwarded by EX.
REQ-010 SHALL have port stall_o  output  1  freeze IF/ID/EX while the operation is in progress.
REQ-011 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse; result_o is valid in this cycle.
REQ-013 SHALL have port result_o  output  XLEN  quotient or remainder; held until the next accepted start.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-015 SHALL leave IDLE only when start_i=1 and flush_i=0, latching operands, funct3_i and word_i in that cycle T.
REQ-016 SHALL go from IDLE to DONE at T+1 on a special case (REQ-022/023), otherwise to CALC with iteration counter N (N=XLEN, or XLEN/2 if word_i).
REQ-017 SHALL perform in CALC one restoring radix-2 step per cycle on operand magnitudes (unsigned for divu/remu), decrementing the counter, and go to FIX after N cycles.
REQ-018 SHALL in FIX (one cycle) negate the quotient if the operand signs differ, negate the remainder if the dividend is negative (signed ops only), select quotient or remainder, then go to DONE.
REQ-019 SHALL in DONE assert done_o for exactly one cycle and return to IDLE the next cycle, giving done_o at T+N+2 for normal operations (T+66 for 64-bit, T+34 for W).
REQ-020 SHALL drive stall_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==FIX, and keep stall_o low in DONE so the pipeline advances and captures result_o.
REQ-021 SHALL for word_i take the low XLEN/2 bits of each operand (sign- or zero-extended per op) and sign-extend bit XLEN/2-1 of the result to XLEN.
REQ-022 SHALL on divide by zero return an all-ones quotient and a remainder equal to the (word-truncated) dividend.
REQ-023 SHALL on signed overflow (most-negative / -1, at the effective width) return quotient = dividend and remainder 0.
REQ-024 SHALL ignore start_i while busy_o=1.
REQ-025 SHALL on flush_i=1 in any state go to IDLE next cycle with no done_o and result_o unchanged; flush_i takes priority over a simultaneous start_i.
REQ-026 SHALL accept a new start_i in the cycle immediately after DONE, since the state is then IDLE.

Reset
REQ-027 SHALL on rst=1 at a clock edge force state IDLE, clear counter and operand registers, and set result_o=0, done_o=0, busy_o=0, stall_o=0, regardless of the operation in progress.
REQ-028 SHALL give rst priority over flush_i and start_i.

Verification
REQ-029 SHALL cover: divu 100/7 started at T -> stall_o high T..T+65, done_o at T+66, result_o=14.
REQ-030 SHALL cover: rem -7 % 2 (64-bit) -> result_o=0xFFFF_FFFF_FFFF_FFFF at T+66.
REQ-031 SHALL cover: divw, dividend 0x0000_0000_FFFF_FFF9 / 2 -> result_o=0xFFFF_FFFF_FFFF_FFFD at T+34.
REQ-032 SHALL cover: div 5/0 -> result_o=0xFFFF_FFFF_FFFF_FFFF at T+1, and remu 5/0 -> result_o=5.
REQ-033 SHALL cover: div 0x8000_0000_0000_0000 / -1 -> result_o=0x8000_0000_0000_0000, and rem of the same operands -> 0, both at T+1.
REQ-034 SHALL cover: flush_i at T+10 -> busy_o=0 at T+11 and no done_o; a new start at T+12 completes normally. Asserting rst mid-CALC gives all outputs 0 on the next cycle.
